// File: rtl/parking_pkg.sv
// Shared types and constants for the parking request front-end.
package parking_pkg;

    localparam int PLATE_W = 16;

    localparam logic DIR_IN  = 1'b0;
    localparam logic DIR_OUT = 1'b1;

    localparam logic [1:0] ERR_CONFLICT  = 2'b00;
    localparam logic [1:0] ERR_BAD_PLATE = 2'b01;
    localparam logic [1:0] ERR_FULL      = 2'b10;
    localparam logic [1:0] ERR_LEAK      = 2'b11;

    typedef struct packed {
        logic [PLATE_W-1:0] plate;
        logic               dir;
    } req_entry_t;

endpackage

// File: rtl/parking_plate_check.sv
// Combinational BCD plate validator: every nibble must be 0..9 and the
// plate must not be all zeros.
module parking_plate_check
    import parking_pkg::*;
(
    input  logic [PLATE_W-1:0] plate_i,
    output logic               plate_ok_o
);

    logic digits_ok;

    // Scan every nibble for a non-BCD digit.
    always_comb begin
        digits_ok = 1'b1;
        for (int n = 0; n < PLATE_W / 4; n++) begin
            if (plate_i[n*4 +: 4] > 4'd9) begin
                digits_ok = 1'b0;
            end
        end
    end

    assign plate_ok_o = digits_ok && (plate_i != '0);

endmodule

// File: rtl/parking_request_queue.sv
// Request front-end for the parking lot controller: validates entry/exit
// pulses, queues accepted requests FIFO-style, and hands them to the
// controller over valid/ready. Rejections produce a one-cycle err_flag.
// Optional build macro: PARKING_REQ_DUP_FILTER_EN drops requests whose
// {plate, dir} already sits in the queue (reported as ERR_FULL).
module parking_request_queue
    import parking_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [PLATE_W-1:0] license_plate,
    input  logic               in_mode,
    input  logic               out_mode,
    input  logic               leakage,
    output logic               req_valid,
    input  logic               req_ready,
    output logic [PLATE_W-1:0] req_plate,
    output logic               req_dir,
    output logic [CNT_W-1:0]   queue_count,
    output logic               queue_full,
    output logic               err_flag,
    output logic [1:0]         err_code
);

    localparam int PTR_W = $clog2(DEPTH);

    req_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_flag_q, err_flag_d;
    logic [1:0]       err_code_q, err_code_d;

    logic       plate_ok;
    logic       req;
    logic       push;
    logic       pop;
    logic       full;
    logic       dup_hit;
    req_entry_t new_entry;
    req_entry_t head;

    parking_plate_check u_plate_check (
        .plate_i    (license_plate),
        .plate_ok_o (plate_ok)
    );

    assign req             = in_mode | out_mode;
    assign new_entry.plate = license_plate;
    assign new_entry.dir   = out_mode ? DIR_OUT : DIR_IN;
    assign full            = (count_q == CNT_W'(DEPTH));

`ifdef PARKING_REQ_DUP_FILTER_EN
    logic [DEPTH-1:0] match;

    // One comparator per slot; a slot only counts if it lies inside the
    // occupied window starting at the read pointer.
    for (genvar i = 0; i < DEPTH; i++) begin : g_dup
        logic [PTR_W-1:0] off;
        assign off      = PTR_W'(i) - rd_ptr_q;
        assign match[i] = (CNT_W'(off) < count_q) && (mem_q[i] == new_entry);
    end

    assign dup_hit = |match;
`else
    assign dup_hit = 1'b0;
`endif

    // Validate the sampled request; first failing check sets the code.
    always_comb begin
        err_flag_d = 1'b0;
        err_code_d = ERR_CONFLICT;
        push       = 1'b0;
        if (req) begin
            err_flag_d = 1'b1;
            if (in_mode && out_mode) begin
                err_code_d = ERR_CONFLICT;
            end else if (!plate_ok) begin
                err_code_d = ERR_BAD_PLATE;
            end else if (in_mode && leakage) begin
                err_code_d = ERR_LEAK;
            end else if (dup_hit) begin
                err_code_d = ERR_FULL;
            end else if (full) begin
                // Judged on the pre-edge count: a same-edge pop does not
                // make room.
                err_code_d = ERR_FULL;
            end else begin
                err_flag_d = 1'b0;
                push       = 1'b1;
            end
        end
    end

    assign pop = req_valid & req_ready;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue state, storage and registered error pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_flag_q <= 1'b0;
            err_code_q <= ERR_CONFLICT;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_flag_q <= err_flag_d;
            err_code_q <= err_code_d;
            if (push) begin
                mem_q[wr_ptr_q] <= new_entry;
            end
        end
    end

    // Head is read straight from storage, so it stays put while stalled;
    // zeros are shown whenever the queue is empty.
    assign head        = mem_q[rd_ptr_q];
    assign req_valid   = (count_q != '0);
    assign req_plate   = req_valid ? head.plate : '0;
    assign req_dir     = req_valid ? head.dir : 1'b0;
    assign queue_count = count_q;
    assign queue_full  = full;
    assign err_flag    = err_flag_q;
    assign err_code    = err_code_q;

endmodule
